// File: rtl/fir_coll_pkg.sv
// Shared types and sizes for the FIR output collector.
// FIRCOLL_SEQ_EN adds an 8-bit per-channel sequence number to every word.
package fir_coll_pkg;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 18;
    localparam int CH_W   = 2;
    localparam int SEQ_W  = 8;

`ifdef FIRCOLL_SEQ_EN
    localparam int ENTRY_W = DATA_W + SEQ_W;

    typedef struct packed {
        logic [CH_W-1:0]   chan;
        logic [DATA_W-1:0] data;
        logic [SEQ_W-1:0]  seq;
    } coll_word_t;
`else
    localparam int ENTRY_W = DATA_W;

    typedef struct packed {
        logic [CH_W-1:0]   chan;
        logic [DATA_W-1:0] data;
    } coll_word_t;
`endif

endpackage

// File: rtl/fir_coll_fifo.sv
// Per-channel synchronous FIFO; pointers carry one extra wrap bit so full/empty
// come from the MSB. A push into a full FIFO is legal only when popping in the same cycle.
module fir_coll_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: empty pointers hide stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/fir_out_collector.sv
// Captures toggle-flagged samples from four FIR channels and merges them round-robin
// onto one valid/ready stream. FIRCOLL_SEQ_EN adds the oSeq port and per-channel counters.
module fir_out_collector
    import fir_coll_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iData0Changed,
    input  logic [DATA_W-1:0] iData0,
    input  logic              iData1Changed,
    input  logic [DATA_W-1:0] iData1,
    input  logic              iData2Changed,
    input  logic [DATA_W-1:0] iData2,
    input  logic              iData3Changed,
    input  logic [DATA_W-1:0] iData3,
    output logic              oValid,
    input  logic              iReady,
    output logic [DATA_W-1:0] oData,
    output logic [CH_W-1:0]   oChan,
    output logic [NUM_CH-1:0] oOverflow,
    input  logic              iOvfClr
`ifdef FIRCOLL_SEQ_EN
    ,
    output logic [SEQ_W-1:0]  oSeq
`endif
);

    logic [NUM_CH-1:0]  tog, chg, push, pop, drop, full, empty;
    logic [NUM_CH-1:0]  prev_q, prev_d, ovf_q, ovf_d;
    logic               armed_q, armed_d;
    logic [CH_W-1:0]    rr_q, rr_d;
    logic               valid_q, valid_d;
    coll_word_t         out_q, out_d;
    logic [DATA_W-1:0]  din    [NUM_CH];
    logic [ENTRY_W-1:0] wentry [NUM_CH];
    logic [ENTRY_W-1:0] rentry [NUM_CH];
    logic [CH_W-1:0]    grant, idx;
    logic               grant_vld, load;
`ifdef FIRCOLL_SEQ_EN
    logic [SEQ_W-1:0]   cnt_q [NUM_CH];
    logic [SEQ_W-1:0]   cnt_d [NUM_CH];
`endif

    assign tog    = {iData3Changed, iData2Changed, iData1Changed, iData0Changed};
    assign din[0] = iData0;
    assign din[1] = iData1;
    assign din[2] = iData2;
    assign din[3] = iData3;

    // Round-robin: first non-empty FIFO at or after rr_q.
    always_comb begin
        grant_vld = 1'b0;
        grant     = rr_q;
        idx       = rr_q;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = rr_q + CH_W'(k);
            if (!grant_vld && !empty[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
    end

    always_comb begin
        load    = (!valid_q || iReady) && grant_vld;
        pop     = load ? (NUM_CH'(1) << grant) : '0;
        // Nothing is captured on the arming edge, only the toggle levels.
        chg     = armed_q ? (tog ^ prev_q) : '0;
        push    = chg & (~full | pop);
        drop    = chg & full & ~pop;
        ovf_d   = (iOvfClr ? '0 : ovf_q) | drop;
        prev_d  = tog;
        armed_d = 1'b1;
        rr_d    = load ? grant + CH_W'(1) : rr_q;
        valid_d = valid_q;
        out_d   = out_q;
        if (load) begin
            valid_d    = 1'b1;
            out_d.chan = grant;
            out_d.data = rentry[grant][DATA_W-1:0];
`ifdef FIRCOLL_SEQ_EN
            out_d.seq  = rentry[grant][ENTRY_W-1:DATA_W];
`endif
        end else if (iReady) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
`ifdef FIRCOLL_SEQ_EN
            // Counter advances on every change, dropped or not, so gaps are visible.
            wentry[ch] = {cnt_q[ch], din[ch]};
            cnt_d[ch]  = cnt_q[ch] + SEQ_W'(chg[ch]);
`else
            wentry[ch] = din[ch];
`endif
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        fir_coll_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (iClk),
            .rst_n (iRst),
            .push  (push[ch]),
            .pop   (pop[ch]),
            .wdata (wentry[ch]),
            .rdata (rentry[ch]),
            .full  (full[ch]),
            .empty (empty[ch])
        );
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            prev_q  <= '0;
            armed_q <= 1'b0;
            rr_q    <= '0;
            ovf_q   <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            prev_q  <= prev_d;
            armed_q <= armed_d;
            rr_q    <= rr_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

`ifdef FIRCOLL_SEQ_EN
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            for (int ch = 0; ch < NUM_CH; ch++) cnt_q[ch] <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) cnt_q[ch] <= cnt_d[ch];
        end
    end

    assign oSeq = out_q.seq;
`endif

    assign oValid    = valid_q;
    assign oData     = out_q.data;
    assign oChan     = out_q.chan;
    assign oOverflow = ovf_q;

endmodule

// File: tb/tb_fir_out_collector.sv
// Directed bench for fir_out_collector: a queue-based reference model checked every
// cycle, plus literal expectations on the captured output beats.
module tb_fir_out_collector;

    localparam int DEPTH = 4;

    logic        iClk = 1'b0;
    logic        iRst = 1'b0;
    logic        iData0Changed = 1'b0, iData1Changed = 1'b0;
    logic        iData2Changed = 1'b0, iData3Changed = 1'b0;
    logic [17:0] iData0 = '0, iData1 = '0, iData2 = '0, iData3 = '0;
    logic        iReady = 1'b1;
    logic        iOvfClr = 1'b0;
    logic        oValid;
    logic [17:0] oData;
    logic [1:0]  oChan;
    logic [3:0]  oOverflow;
    logic [7:0]  seq_out;
`ifdef FIRCOLL_SEQ_EN
    logic [7:0]  oSeq;
    assign seq_out = oSeq;
`else
    assign seq_out = 8'd0;
`endif

    int vectors = 0;
    int miscompares = 0;

    fir_out_collector #(.FIFO_DEPTH(DEPTH)) dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iData0Changed (iData0Changed),
        .iData0        (iData0),
        .iData1Changed (iData1Changed),
        .iData1        (iData1),
        .iData2Changed (iData2Changed),
        .iData2        (iData2),
        .iData3Changed (iData3Changed),
        .iData3        (iData3),
        .oValid        (oValid),
        .iReady        (iReady),
        .oData         (oData),
        .oChan         (oChan),
        .oOverflow     (oOverflow),
        .iOvfClr       (iOvfClr)
`ifdef FIRCOLL_SEQ_EN
        ,
        .oSeq          (oSeq)
`endif
    );

    initial forever #5 iClk = ~iClk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: per-channel queues, a one-word holding stage, round-robin pointer.
    typedef logic [25:0] ent_t;
    ent_t        mq [4][$];
    logic        m_valid = 1'b0;
    logic [17:0] m_data = '0;
    logic [1:0]  m_chan = '0;
    logic [7:0]  m_seq = '0;
    int          m_rr = 0;
    logic [3:0]  m_prev = '0;
    logic [3:0]  m_ovf = '0;
    logic        m_armed = 1'b0;
    logic [7:0]  m_cnt [4] = '{default: 8'd0};

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            mq[c].delete();
            m_cnt[c] = 8'd0;
        end
        m_valid = 1'b0; m_data = '0; m_chan = '0; m_seq = '0;
        m_rr = 0; m_prev = '0; m_ovf = '0; m_armed = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0]  tg;
        logic [17:0] dv [4];
        bit          any;
        bit          got;
        int          g;
        ent_t        e;
        tg = {iData3Changed, iData2Changed, iData1Changed, iData0Changed};
        dv[0] = iData0; dv[1] = iData1; dv[2] = iData2; dv[3] = iData3;
        any = 0;
        for (int c = 0; c < 4; c++) if (mq[c].size() > 0) any = 1;
        if ((!m_valid || iReady) && any) begin
            got = 0; g = 0;
            for (int k = 0; k < 4; k++) begin
                if (!got && mq[(m_rr + k) % 4].size() > 0) begin
                    got = 1; g = (m_rr + k) % 4;
                end
            end
            e = mq[g].pop_front();
            m_valid = 1'b1;
            m_data  = e[17:0];
            m_seq   = e[25:18];
            m_chan  = 2'(g);
            m_rr    = (g + 1) % 4;
        end else if (iReady) begin
            m_valid = 1'b0;
        end
        if (iOvfClr) m_ovf = '0;
        for (int c = 0; c < 4; c++) begin
            if (m_armed && (tg[c] != m_prev[c])) begin
                if (mq[c].size() < DEPTH) mq[c].push_back({m_cnt[c], dv[c]});
                else m_ovf[c] = 1'b1;
                m_cnt[c] = m_cnt[c] + 8'd1;
            end
        end
        m_prev  = tg;
        m_armed = 1'b1;
    endtask

    initial forever begin
        @(posedge iClk or negedge iRst);
        if (!iRst) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge iClk);
        check("valid", 32'(oValid), 32'(m_valid));
        if (m_valid) begin
            check("data", 32'(oData), 32'(m_data));
            check("chan", 32'(oChan), 32'(m_chan));
`ifdef FIRCOLL_SEQ_EN
            check("seq", 32'(seq_out), 32'(m_seq));
`endif
        end
        check("overflow", 32'(oOverflow), 32'(m_ovf));
    end

    // Log of transferred beats for literal checks.
    typedef struct {
        int          cyc;
        logic [1:0]  chan;
        logic [17:0] data;
        logic [7:0]  seq;
    } beat_t;
    beat_t beats [$];
    int    cyc = 0;

    initial forever begin
        beat_t b;
        @(posedge iClk);
        if (iRst && oValid && iReady) begin
            b.cyc = cyc; b.chan = oChan; b.data = oData; b.seq = seq_out;
            beats.push_back(b);
        end
        cyc++;
    end

    task automatic tick();
        @(posedge iClk);
        #2;
    endtask

    initial begin
        int base;
        repeat (2) @(posedge iClk);
        #2;
        check("rst_valid", 32'(oValid), 32'd0);
        check("rst_data", 32'(oData), 32'd0);
        check("rst_chan", 32'(oChan), 32'd0);
        check("rst_ovf", 32'(oOverflow), 32'd0);

        // Single sample on ch1
        iRst = 1'b1;
        tick();
        base = beats.size();
        iData1 = 18'h12345;
        iData1Changed = ~iData1Changed;
        tick();
        check("lat_e0_valid", 32'(oValid), 32'd0);
        tick();
        check("lat_e1_valid", 32'(oValid), 32'd1);
        check("lat_e1_chan", 32'(oChan), 32'd1);
        check("lat_e1_data", 32'(oData), 32'h12345);
        tick();
        check("single_beat_valid", 32'(oValid), 32'd0);
        check("single_beat_count", 32'(beats.size() - base), 32'd1);

        // Toggles high across reset release must not produce samples
        iRst = 1'b0;
        tick();
        {iData3Changed, iData2Changed, iData1Changed, iData0Changed} = 4'hF;
        tick();
        iRst = 1'b1;
        base = beats.size();
        repeat (4) begin
            tick();
            check("arm_quiet", 32'(oValid), 32'd0);
        end
        check("arm_no_beats", 32'(beats.size() - base), 32'd0);
        iData0 = 18'hA0; iData1 = 18'hA1; iData2 = 18'hA2; iData3 = 18'hA3;
        {iData3Changed, iData2Changed, iData1Changed, iData0Changed} = 4'h0;
        repeat (6) tick();
        check("all4_count", 32'(beats.size() - base), 32'd4);
        if (beats.size() - base == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("all4_chan", 32'(beats[base+k].chan), 32'(k));
                check("all4_data", 32'(beats[base+k].data), 32'h0A0 + 32'(k));
                check("all4_cyc", 32'(beats[base+k].cyc - beats[base].cyc), 32'(k));
            end
        end

        // Stall: held word must stay stable
        iReady = 1'b0;
        iData0 = 18'h3C;
        iData0Changed = 1'b1;
        tick();
        tick();
        check("stall_valid", 32'(oValid), 32'd1);
        repeat (5) begin
            tick();
            check("stall_hold_valid", 32'(oValid), 32'd1);
            check("stall_hold_data", 32'(oData), 32'h3C);
            check("stall_hold_chan", 32'(oChan), 32'd0);
        end
        base = beats.size();
        iReady = 1'b1;
        tick();
        check("stall_xfer_count", 32'(beats.size() - base), 32'd1);
        if (beats.size() > base) check("stall_xfer_data", 32'(beats[base].data), 32'h3C);
        check("stall_after_valid", 32'(oValid), 32'd0);

        // Overflow on ch2: six samples into a four-deep FIFO plus the holding stage
        iReady = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            iData2 = 18'(v);
            iData2Changed = ~iData2Changed;
            tick();
        end
        check("ovf_flag", 32'(oOverflow), 32'h4);
        base = beats.size();
        iReady = 1'b1;
        repeat (7) tick();
        check("ovf_drain_count", 32'(beats.size() - base), 32'd5);
        if (beats.size() - base == 5) begin
            for (int k = 0; k < 5; k++) begin
                check("ovf_drain_data", 32'(beats[base+k].data), 32'(k + 1));
                check("ovf_drain_chan", 32'(beats[base+k].chan), 32'd2);
            end
        end
        check("ovf_sticky", 32'(oOverflow), 32'h4);
        iOvfClr = 1'b1;
        tick();
        iOvfClr = 1'b0;
        check("ovf_cleared", 32'(oOverflow), 32'h0);

        // Alternating ch0/ch3 stream at one sample per cycle
        base = beats.size();
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) begin
                iData0 = 18'h100 + 18'(i);
                iData0Changed = ~iData0Changed;
            end else begin
                iData3 = 18'h300 + 18'(i);
                iData3Changed = ~iData3Changed;
            end
            tick();
        end
        repeat (3) tick();
        check("alt_count", 32'(beats.size() - base), 32'd12);
        if (beats.size() - base == 12) begin
            for (int k = 0; k < 12; k++) begin
                check("alt_chan", 32'(beats[base+k].chan), (k % 2 == 0) ? 32'd0 : 32'd3);
                check("alt_data", 32'(beats[base+k].data),
                      ((k % 2 == 0) ? 32'h100 : 32'h300) + 32'(k));
            end
        end
        check("alt_no_ovf", 32'(oOverflow), 32'h0);

        // Reset in the middle of a stream
        for (int i = 0; i < 4; i++) begin
            iData0 = 18'h200 + 18'(i);
            iData0Changed = ~iData0Changed;
            iData3 = 18'h280 + 18'(i);
            iData3Changed = ~iData3Changed;
            tick();
        end
        check("pre_rst_valid", 32'(oValid), 32'd1);
        iRst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(oValid), 32'd0);
        check("mid_rst_ovf", 32'(oOverflow), 32'h0);
        tick();
        iRst = 1'b1;
        base = beats.size();
        repeat (6) tick();
        check("rearm_no_stale", 32'(beats.size() - base), 32'd0);
        check("rearm_valid", 32'(oValid), 32'd0);

`ifdef FIRCOLL_SEQ_EN
        // Sequence numbers wrap at 256
        iRst = 1'b0;
        tick();
        iRst = 1'b1;
        tick();
        base = beats.size();
        for (int i = 0; i < 300; i++) begin
            iData1 = 18'(i);
            iData1Changed = ~iData1Changed;
            tick();
        end
        repeat (4) tick();
        check("seq_count", 32'(beats.size() - base), 32'd300);
        if (beats.size() - base == 300) begin
            for (int k = 0; k < 300; k++) begin
                check("seq_val", 32'(beats[base+k].seq), 32'(k % 256));
                check("seq_data", 32'(beats[base+k].data), 32'(k));
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
